// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, parity modes,
// default parameter values and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_STOP_BITS    = 1;

    // Data is zero-extended to 9 bits, so padding does not change the XOR.
    function automatic logic parity_of(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit. A clear forces the count back to zero.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity bit
// (compile-time macro UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              parity_odd,
    output logic              tx_ready,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_done,
    output state_t            state_dbg
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    // Handshake: a frame is taken on any rising edge where tx_valid && tx_ready;
    // tx_ready never depends on tx_valid, and the payload is copied at that edge.
    state_t            state, state_next;
    logic [DATA_W-1:0] shift_q, shift_next;
    logic [BW-1:0]     bit_cnt, bit_cnt_next;
    logic              stop_cnt, stop_cnt_next;
    logic              txd_next, bit_end, baud_clear, accept, last_stop;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_next;
`else
    logic unused_parity;
    assign unused_parity = parity_odd;
`endif

    assign last_stop  = (STOP_BITS == 1) || stop_cnt;
    assign baud_clear = (state == ST_IDLE) || (state_next != state);
    assign state_dbg  = state;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    always_comb begin
        state_next    = state;
        shift_next    = shift_q;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        tx_ready      = 1'b0;
        tx_busy       = 1'b1;
        tx_done       = 1'b0;
        accept        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next      = par_q;
`endif
        case (state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                tx_busy  = 1'b0;
            end
            ST_START: if (bit_end) state_next = ST_DATA;
            ST_DATA: if (bit_end) begin
                shift_next = shift_q >> 1;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                    state_next   = ST_PARITY;
`else
                    state_next   = ST_STOP;
`endif
                end else begin
                    bit_cnt_next = bit_cnt + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_end) state_next = ST_STOP;
`endif
            ST_STOP: if (bit_end) begin
                if (last_stop) begin
                    tx_ready      = 1'b1;
                    tx_done       = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = ST_IDLE;
                end else begin
                    stop_cnt_next = 1'b1;
                end
            end
            // Unreachable encodings recover to idle without accepting a frame.
            default: begin
                state_next = ST_IDLE;
                tx_busy    = 1'b0;
            end
        endcase

        accept = tx_valid && tx_ready;
        if (accept) begin
            state_next = ST_START;
            shift_next = tx_data;
`ifdef UART_TX_PARITY_EN
            par_next   = parity_of(9'(tx_data), parity_odd);
`endif
        end
    end

    // txd is registered from the next-state view so the line changes on the
    // same edge as the state, e.g. it falls right after acceptance.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_next = par_next;
`endif
            default:   txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            txd      <= txd_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset_n) par_q <= 1'b0;
        else          par_q <= par_next;
    end
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: a wide instance (8 data bits, 16 clocks/bit,
// 1 stop bit) and a narrow instance (7 data bits, 4 clocks/bit, 2 stop bits).
module tb_uart_tx_core;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Hand-computed frame lengths: (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT.
    localparam int LEN_A = (P == 1) ? 176 : 160;
    localparam int LEN_B = (P == 1) ? 44 : 40;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       parity_odd;
    logic       a_valid, a_ready, a_txd, a_busy, a_done;
    logic [7:0] a_data;
    state_t     a_state;
    logic       b_valid, b_ready, b_txd, b_busy, b_done;
    logic [6:0] b_data;
    state_t     b_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [8:0] data;
        logic       odd;
        logic       exp_par;
        int         sel;
        int         exp_len;
    } vec_t;
    vec_t vecs[8];

    uart_tx_core #(.DATA_W(8), .CLKS_PER_BIT(16), .STOP_BITS(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .tx_valid(a_valid), .tx_data(a_data),
        .parity_odd(parity_odd), .tx_ready(a_ready), .txd(a_txd), .tx_busy(a_busy),
        .tx_done(a_done), .state_dbg(a_state)
    );

    uart_tx_core #(.DATA_W(7), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .tx_valid(b_valid), .tx_data(b_data),
        .parity_odd(parity_odd), .tx_ready(b_ready), .txd(b_txd), .tx_busy(b_busy),
        .tx_done(b_done), .state_dbg(b_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rd_txd(input int sel);   return (sel == 1) ? b_txd   : a_txd;   endfunction
    function automatic logic rd_busy(input int sel);  return (sel == 1) ? b_busy  : a_busy;  endfunction
    function automatic logic rd_ready(input int sel); return (sel == 1) ? b_ready : a_ready; endfunction
    function automatic logic rd_done(input int sel);  return (sel == 1) ? b_done  : a_done;  endfunction

    task automatic push_frame(input logic [8:0] data, input int dw, input logic par, input int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < dw; i++) exp_q.push_back(data[i]);
        if (P == 1) exp_q.push_back(par);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    task automatic drive(input int sel, input logic valid, input logic [8:0] data);
        if (sel == 1) begin b_valid = valid; b_data = data[6:0]; end
        else          begin a_valid = valid; a_data = data[7:0]; end
    endtask

    // One frame: offer, scramble inputs right after acceptance, then check txd
    // every cycle against the expected bit stream and the tx_done position.
    task automatic run_frame(input vec_t v);
        int cpb, len, done_n, done_at;
        cpb = (v.sel == 1) ? 4 : 16;
        exp_q.delete();
        push_frame(v.data, (v.sel == 1) ? 7 : 8, v.exp_par, (v.sel == 1) ? 2 : 1);
        len = exp_q.size() * cpb;
        @(negedge clock);
        chk("accept_ready", rd_ready(v.sel), 1);
        parity_odd = v.odd;
        drive(v.sel, 1'b1, v.data);
        @(negedge clock);
        drive(v.sel, 1'b0, ~v.data);
        parity_odd = ~v.odd;
        done_n = 0;
        done_at = 0;
        for (int c = 1; c <= len; c++) begin
            chk("frame_txd", rd_txd(v.sel), exp_q[0]);
            chk("frame_busy", rd_busy(v.sel), 1);
            if (rd_done(v.sel)) begin done_n++; done_at = c; end
            if ((c % cpb) == 0) void'(exp_q.pop_front());
            @(negedge clock);
        end
        chk("done_count", done_n, 1);
        chk("done_cycle", done_at, v.exp_len);
        chk("idle_txd", rd_txd(v.sel), 1);
        chk("idle_busy", rd_busy(v.sel), 0);
        chk("idle_ready", rd_ready(v.sel), 1);
    endtask

    // tx_valid held high across two frames: no gap, one ready cycle per frame.
    task automatic back_to_back();
        int ready_n, done_n;
        logic ready_at_l;
        exp_q.delete();
        push_frame(9'h0A5, 8, 1'b0, 1);
        push_frame(9'h03C, 8, 1'b0, 1);
        parity_odd = PARITY_EVEN;
        @(negedge clock);
        drive(0, 1'b1, 9'h0A5);
        @(negedge clock);
        drive(0, 1'b1, 9'h03C);
        ready_n = 0;
        done_n = 0;
        ready_at_l = 1'b0;
        for (int c = 1; c <= 2 * LEN_A; c++) begin
            if (c == LEN_A + 1) drive(0, 1'b0, 9'h000);
            chk("b2b_txd", a_txd, exp_q[0]);
            if (a_ready) ready_n++;
            if (a_done) done_n++;
            if (c == LEN_A) ready_at_l = a_ready;
            if ((c % 16) == 0) void'(exp_q.pop_front());
            @(negedge clock);
        end
        chk("b2b_ready_pulses", ready_n, 2);
        chk("b2b_ready_at_first_end", ready_at_l, 1);
        chk("b2b_done_pulses", done_n, 2);
        chk("b2b_idle_after", a_busy, 0);
    endtask

    // Reset pulse during data bit 3 aborts the frame cleanly.
    task automatic reset_mid_frame();
        int done_n;
        done_n = 0;
        parity_odd = PARITY_EVEN;
        @(negedge clock);
        drive(0, 1'b1, 9'h05A);
        @(negedge clock);
        drive(0, 1'b0, 9'h000);
        for (int c = 1; c < 70; c++) begin
            if (a_done) done_n++;
            @(negedge clock);
        end
        chk("rst_in_data", a_state, ST_DATA);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        chk("rst_txd", a_txd, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_state", a_state, ST_IDLE);
        for (int c = 0; c < 200; c++) begin
            if (a_done) done_n++;
            @(negedge clock);
        end
        chk("rst_no_done", done_n, 0);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        vecs[0] = '{9'h055, PARITY_EVEN, 1'b0, 0, LEN_A};
        vecs[1] = '{9'h001, PARITY_ODD,  1'b0, 0, LEN_A};
        vecs[2] = '{9'h003, PARITY_ODD,  1'b1, 0, LEN_A};
        vecs[3] = '{9'h0FF, PARITY_EVEN, 1'b0, 0, LEN_A};
        vecs[4] = '{9'h080, PARITY_EVEN, 1'b1, 0, LEN_A};
        vecs[5] = '{9'h03C, PARITY_ODD,  1'b1, 0, LEN_A};
        vecs[6] = '{9'h055, PARITY_EVEN, 1'b0, 1, LEN_B};
        vecs[7] = '{9'h02A, PARITY_ODD,  1'b0, 1, LEN_B};

        reset_n = 1'b0;
        parity_odd = 1'b0;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        repeat (3) @(negedge clock);
        chk("reset_a_txd", a_txd, 1);
        chk("reset_a_busy", a_busy, 0);
        chk("reset_a_done", a_done, 0);
        chk("reset_a_ready", a_ready, 1);
        chk("reset_a_state", a_state, ST_IDLE);
        chk("reset_b_txd", b_txd, 1);
        chk("reset_b_ready", b_ready, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);
        back_to_back();
        reset_mid_frame();
        run_frame('{9'h0C3, PARITY_EVEN, 1'b0, 0, LEN_A});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-003 Parameter STOP_BITS, default 1, stop bit periods per frame; legal values 1 or 2.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous, active-low.
REQ-006 tx_valid  input  1  a frame is offered on tx_data.
REQ-007 tx_data  input  DATA_W  frame payload; transmitted LSB first.
REQ-008 parity_odd  input  1  1 = odd parity, 0 = even parity; sampled at acceptance.
REQ-009 tx_ready  output  1  core can accept a frame this cycle.
REQ-010 txd  output  1  serial line; idle high.
REQ-011 tx_busy  output  1  a frame is in progress.
REQ-012 tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Function
REQ-013 States: IDLE, START, DATA, PARITY, STOP; encoding constants are held in the shared package.
REQ-014 Acceptance: a frame is accepted in any cycle where tx_valid && tx_ready.
  - tx_data and parity_odd are captured into internal registers on acceptance.
  - Later changes on tx_data and parity_odd do not affect the frame in progress.
REQ-015 tx_ready is high in IDLE.
  - It is also high in the final cycle of the last stop bit.
  - It is low in every other cycle.
REQ-016 Baud counter: runs 0..CLKS_PER_BIT-1, cleared on every state entry; bit_end is asserted when count == CLKS_PER_BIT-1.
REQ-017 Transitions:
  - IDLE -> START on acceptance.
  - START -> DATA on bit_end.
  - DATA -> PARITY on bit_end of bit DATA_W-1.
  - PARITY -> STOP on bit_end.
  - STOP -> START on bit_end of the last stop bit with acceptance.
  - STOP -> IDLE on bit_end of the last stop bit without acceptance.
REQ-018 txd values by state:
  - IDLE: 1.
  - START: 0.
  - DATA: current shift register LSB.
  - PARITY: parity bit.
  - STOP: 1.
  - txd is driven from a register.
REQ-019 Latency: txd falls in the first cycle after the acceptance edge.
REQ-020 Data shift: the shift register shifts right by one on each DATA bit_end. The bit counter runs 0..DATA_W-1 and wraps to 0 on exit from DATA.
REQ-021 Parity bit: XOR-reduction of the captured data, inverted when parity_odd was 1 at acceptance.
REQ-022 Frame length: exactly (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 if parity is compiled in, else 0.
REQ-023 Back-to-back frames: acceptance in the final stop cycle starts the next START in the following cycle, with no idle gap. tx_done still pulses in that final cycle.
REQ-024 tx_busy is 0 in IDLE and 1 in all other states.
REQ-025 Unknown or illegal state encodings go to IDLE on the next edge, with outputs at their idle values.

Reset
REQ-026 While reset_n is 0 at a clock edge, the following take these values:
  - state = IDLE
  - txd = 1
  - tx_busy = 0
  - tx_done = 0
  - tx_ready = 1
  - all counters, shift register and captured parity = 0.
REQ-027 Reset mid-frame aborts the frame: txd is 1 in the cycle after the reset edge, and no tx_done is produced.

Configuration
REQ-028 Macro UART_TX_PARITY_EN.
  - Defined: the PARITY state and parity bit are present.
  - Undefined: DATA -> STOP directly, parity_odd is ignored, and no parity logic is synthesised.

Structure
REQ-029 Package uart_pkg holds:
  - state encoding constants;
  - parity mode constants (EVEN = 0, ODD = 1);
  - default parameter values.
REQ-030 One sub-module, uart_baud_cnt, provides the CLKS_PER_BIT counter with a clear input and a bit_end output. All other logic stays in uart_tx_core.

Verification
REQ-031 Setup: DATA_W = 8, CLKS_PER_BIT = 16, parity enabled. Stimulus: tx_data = 0x55, even parity.
  - Expected txd at 16-cycle periods: 0,1,0,1,0,1,0,1,0, parity 0, stop 1.
  - tx_done in cycle 176.
REQ-032 Stimulus: tx_data = 0x01 with odd parity.
  - Expected parity bit = 0.
  - tx_data = 0x03 with odd parity gives parity bit = 1.
REQ-033 Stimulus: tx_valid held high with 0xA5 then 0x3C.
  - Second START begins the cycle after the first tx_done, with no high gap beyond the stop bit.
  - tx_ready pulses for exactly 1 cycle per frame.
REQ-034 Stimulus: reset_n low for 1 cycle during DATA bit 3.
  - txd = 1, tx_busy = 0 and tx_ready = 1 the next cycle.
  - No tx_done.
  - The next accepted frame is transmitted intact.
REQ-035 Setup: UART_TX_PARITY_EN undefined, STOP_BITS = 2, DATA_W = 7, CLKS_PER_BIT = 4.
  - Frame is 40 cycles, with no parity bit.
  - txd stays high for the last 8 cycles.
REQ-036 Stimulus: tx_data changed 1 cycle after acceptance.
  - The transmitted bits equal the originally accepted value.
